// File: rtl/wash_program_sequencer.sv
// Washer program sequencer: steps FILL/WASH/RINSE/DRAIN/SPIN on a 1 s tick,
// runs forward/reverse agitation cycles, and handles pause and emergency stop.
module wash_program_sequencer #(
   parameter int unsigned FILL_S    = 60,
   parameter int unsigned DRAIN_S   = 60,
   parameter int unsigned SPIN_S    = 60,
   parameter int unsigned RUN_S     = 60,
   parameter int unsigned PAUSE_S   = 5,
   parameter int unsigned WASH_CYC  = 7,
   parameter int unsigned RINSE_CYC = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec_tick,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       pause,
   input  logic       estop,
   output logic       inlet,
   output logic       drain,
   output logic       dry,
   output logic       zheng,
   output logic       fan,
   output logic       alarm,
   output logic       busy,
   output logic [2:0] phase,
   output logic [3:0] cyc_left
);

   localparam int unsigned SEC_W = 6;
   localparam int unsigned CYC_W = 4;

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_FILL  = 3'd1;
   localparam logic [2:0] PH_WASH  = 3'd2;
   localparam logic [2:0] PH_RINSE = 3'd3;
   localparam logic [2:0] PH_DRAIN = 3'd4;
   localparam logic [2:0] PH_SPIN  = 3'd5;
   localparam logic [2:0] PH_DONE  = 3'd6;
   localparam logic [2:0] PH_ESTOP = 3'd7;

   localparam logic [1:0] ST_STOP1 = 2'd0;
   localparam logic [1:0] ST_FWD   = 2'd1;
   localparam logic [1:0] ST_STOP2 = 2'd2;
   localparam logic [1:0] ST_REV   = 2'd3;

   logic [1:0]       step, step_n;
   logic [1:0]       mode_q, mode_n;
   logic [SEC_W-1:0] sec_cnt, sec_n, dur;
   logic [CYC_W-1:0] cyc_n;
   logic [2:0]       phase_n, next_ph;
   logic             agit, step_end;

   // Step duration and the phase that follows the current one for the latched mode
   always_comb begin
      dur     = SEC_W'(FILL_S);
      next_ph = PH_DONE;
      agit    = (phase == PH_WASH) || (phase == PH_RINSE);
      case (phase)
         PH_FILL:  next_ph = (mode_q == 2'd2) ? PH_WASH : PH_RINSE;
         PH_WASH:  begin
            dur     = (step == ST_FWD || step == ST_REV) ? SEC_W'(RUN_S) : SEC_W'(PAUSE_S);
            next_ph = PH_RINSE;
         end
         PH_RINSE: begin
            dur     = (step == ST_FWD || step == ST_REV) ? SEC_W'(RUN_S) : SEC_W'(PAUSE_S);
            next_ph = PH_DRAIN;
         end
         PH_DRAIN: begin
            dur     = SEC_W'(DRAIN_S);
            next_ph = (mode_q == 2'd1) ? PH_DONE : PH_SPIN;
         end
         PH_SPIN:  dur = SEC_W'(SPIN_S);
         default:  ;
      endcase
      step_end = sec_tick && !pause && (sec_cnt == dur - SEC_W'(1));
   end

   // Next-state logic; estop overrides everything else
   always_comb begin
      phase_n = phase;
      step_n  = step;
      sec_n   = sec_cnt;
      cyc_n   = cyc_left;
      mode_n  = mode_q;
      if (estop) begin
         phase_n = PH_ESTOP;
         step_n  = ST_STOP1;
         sec_n   = '0;
         cyc_n   = '0;
      end else begin
         case (phase)
            PH_IDLE: if (start && mode != 2'd0) begin
               mode_n  = mode;
               phase_n = (mode == 2'd3) ? PH_DRAIN : PH_FILL;
               step_n  = ST_STOP1;
               sec_n   = '0;
            end
            PH_DONE:  if (start) phase_n = PH_IDLE;
            PH_ESTOP: phase_n = PH_IDLE;
            default: if (sec_tick && !pause) begin
               if (!step_end) begin
                  sec_n = sec_cnt + SEC_W'(1);
               end else begin
                  sec_n = '0;
                  if (agit && step != ST_REV) begin
                     step_n = step + 2'd1;
                  end else if (agit && cyc_left != CYC_W'(1)) begin
                     step_n = ST_STOP1;
                     cyc_n  = cyc_left - CYC_W'(1);
                  end else begin
                     phase_n = next_ph;
                     step_n  = ST_STOP1;
                     cyc_n   = (next_ph == PH_WASH)  ? CYC_W'(WASH_CYC)  :
                               (next_ph == PH_RINSE) ? CYC_W'(RINSE_CYC) : '0;
                  end
               end
            end
         endcase
      end
   end

   // State registers plus registered actuator/indicator decodes of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= PH_IDLE;
         step     <= ST_STOP1;
         sec_cnt  <= '0;
         cyc_left <= '0;
         mode_q   <= 2'd0;
         inlet    <= 1'b0;
         drain    <= 1'b0;
         dry      <= 1'b0;
         zheng    <= 1'b0;
         fan      <= 1'b0;
         alarm    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         phase    <= phase_n;
         step     <= step_n;
         sec_cnt  <= sec_n;
         cyc_left <= cyc_n;
         mode_q   <= mode_n;
         inlet    <= !pause && (phase_n == PH_FILL);
         drain    <= !pause && (phase_n == PH_DRAIN || phase_n == PH_SPIN);
         dry      <= !pause && (phase_n == PH_SPIN);
         zheng    <= !pause && (phase_n == PH_WASH || phase_n == PH_RINSE) && (step_n == ST_FWD);
         fan      <= !pause && (phase_n == PH_WASH || phase_n == PH_RINSE) && (step_n == ST_REV);
         alarm    <= (phase_n == PH_DONE) || (phase_n == PH_ESTOP);
         busy     <= (phase_n >= PH_FILL) && (phase_n <= PH_SPIN);
      end
   end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed table-driven bench for wash_program_sequencer with short test-plan timings.
module tb_wash_program_sequencer;

   logic       clk = 1'b0;
   logic       rst, sec_tick, start, pause, estop;
   logic [1:0] mode;
   logic       inlet, drain, dry, zheng, fan, alarm, busy;
   logic [2:0] phase;
   logic [3:0] cyc_left;

   int n_run  = 0;
   int n_fail = 0;

   wash_program_sequencer #(
      .FILL_S(3), .DRAIN_S(2), .SPIN_S(2), .RUN_S(4), .PAUSE_S(1),
      .WASH_CYC(2), .RINSE_CYC(1)
   ) dut (
      .clk(clk), .rst(rst), .sec_tick(sec_tick), .start(start), .mode(mode),
      .pause(pause), .estop(estop), .inlet(inlet), .drain(drain), .dry(dry),
      .zheng(zheng), .fan(fan), .alarm(alarm), .busy(busy), .phase(phase),
      .cyc_left(cyc_left)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic       st, tk, pa, es;
      logic [1:0] md;
      logic [2:0] ph;
      logic [4:0] act;   // {inlet, drain, dry, zheng, fan}
      logic       al, bz;
      logic [3:0] cy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int n, logic st, logic tk, logic pa, logic es, logic [1:0] md,
                               logic [2:0] ph, logic [4:0] act, logic al, logic bz, logic [3:0] cy);
      vec_t v;
      v.n = n; v.st = st; v.tk = tk; v.pa = pa; v.es = es; v.md = md;
      v.ph = ph; v.act = act; v.al = al; v.bz = bz; v.cy = cy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // One clock edge with the given inputs; pulses drop afterwards, levels persist
   task automatic drive(input logic s, input logic t, input logic p, input logic e, input logic [1:0] m);
      start = s; sec_tick = t; pause = p; estop = e; mode = m;
      @(posedge clk);
      #1;
      start = 1'b0; sec_tick = 1'b0;
      if (zheng && fan) begin
         n_fail++;
         $display("FAIL motor_dir: zheng=%0b fan=%0b both active", zheng, fan);
      end
   endtask

   function automatic logic [13:0] obs();
      return {phase, inlet, drain, dry, zheng, fan, alarm, busy, cyc_left};
   endfunction

   initial begin
      rst = 1'b1; sec_tick = 1'b0; start = 1'b0; pause = 1'b0; estop = 1'b0; mode = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(obs()), 32'(14'h0));

      // Reset in the middle of FILL
      rst = 1'b0;
      drive(1, 0, 0, 0, 2);
      drive(0, 1, 0, 0, 2);
      chk("pre_reset_fill", 32'(obs()), 32'({3'd1, 5'b10000, 1'b0, 1'b1, 4'd0}));
      rst = 1'b1;
      drive(0, 0, 0, 0, 2);
      chk("reset_mid_fill", 32'(obs()), 32'(14'h0));
      rst = 1'b0;

      // Full wash, continuous ticks (37 total)
      tbl.push_back(mk(1, 1,0,0,0, 2, 3'd1, 5'b10000, 0,1, 0));
      tbl.push_back(mk(2, 0,1,0,0, 2, 3'd1, 5'b10000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00000, 0,1, 2));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00010, 0,1, 2));
      tbl.push_back(mk(3, 0,1,0,0, 2, 3'd2, 5'b00010, 0,1, 2));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00000, 0,1, 2));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00001, 0,1, 2));
      tbl.push_back(mk(3, 0,1,0,0, 2, 3'd2, 5'b00001, 0,1, 2));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00000, 0,1, 1));
      tbl.push_back(mk(10,0,1,0,0, 2, 3'd3, 5'b00000, 0,1, 1));
      tbl.push_back(mk(9, 0,1,0,0, 2, 3'd3, 5'b00001, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd4, 5'b01000, 0,1, 0));
      tbl.push_back(mk(2, 0,1,0,0, 2, 3'd5, 5'b01100, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd5, 5'b01100, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd6, 5'b00000, 1,0, 0));
      tbl.push_back(mk(3, 0,1,0,0, 2, 3'd6, 5'b00000, 1,0, 0));
      tbl.push_back(mk(1, 1,0,0,0, 2, 3'd0, 5'b00000, 0,0, 0));
      // Mode 0 start is ignored
      tbl.push_back(mk(1, 1,0,0,0, 0, 3'd0, 5'b00000, 0,0, 0));
      // Spin only
      tbl.push_back(mk(1, 1,0,0,0, 3, 3'd4, 5'b01000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 3, 3'd4, 5'b01000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 3, 3'd5, 5'b01100, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 3, 3'd5, 5'b01100, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 3, 3'd6, 5'b00000, 1,0, 0));
      tbl.push_back(mk(1, 1,0,0,0, 3, 3'd0, 5'b00000, 0,0, 0));
      // Start with coincident tick, then estop during WASH REV
      tbl.push_back(mk(1, 1,1,0,0, 2, 3'd1, 5'b10000, 0,1, 0));
      tbl.push_back(mk(2, 0,1,0,0, 2, 3'd1, 5'b10000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 2, 3'd2, 5'b00000, 0,1, 2));
      tbl.push_back(mk(6, 0,1,0,0, 2, 3'd2, 5'b00001, 0,1, 2));
      tbl.push_back(mk(1, 0,1,0,1, 2, 3'd7, 5'b00000, 1,0, 0));
      tbl.push_back(mk(1, 1,0,0,1, 2, 3'd7, 5'b00000, 1,0, 0));
      tbl.push_back(mk(1, 0,0,0,0, 2, 3'd0, 5'b00000, 0,0, 0));
      // Rinse with a pause during FWD
      tbl.push_back(mk(1, 1,0,0,0, 1, 3'd1, 5'b10000, 0,1, 0));
      tbl.push_back(mk(3, 0,1,0,0, 1, 3'd3, 5'b00000, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd3, 5'b00010, 0,1, 1));
      tbl.push_back(mk(2, 0,1,0,0, 1, 3'd3, 5'b00010, 0,1, 1));
      tbl.push_back(mk(5, 0,1,1,0, 1, 3'd3, 5'b00000, 0,1, 1));
      tbl.push_back(mk(1, 0,0,0,0, 1, 3'd3, 5'b00010, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd3, 5'b00010, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd3, 5'b00000, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd3, 5'b00001, 0,1, 1));
      tbl.push_back(mk(3, 0,1,0,0, 1, 3'd3, 5'b00001, 0,1, 1));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd4, 5'b01000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd4, 5'b01000, 0,1, 0));
      tbl.push_back(mk(1, 0,1,0,0, 1, 3'd6, 5'b00000, 1,0, 0));
      tbl.push_back(mk(1, 1,0,1,0, 1, 3'd0, 5'b00000, 0,0, 0));

      foreach (tbl[i]) begin
         repeat (tbl[i].n) drive(tbl[i].st, tbl[i].tk, tbl[i].pa, tbl[i].es, tbl[i].md);
         chk($sformatf("vec%0d", i), 32'(obs()),
             32'({tbl[i].ph, tbl[i].act, tbl[i].al, tbl[i].bz, tbl[i].cy}));
      end

      // Mode change after start is ignored: launched as rinse, still rinse after FILL
      drive(1, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 2);
      drive(0, 1, 0, 0, 3);
      drive(0, 1, 0, 0, 2);
      chk("mode_locked", 32'(phase), 32'(3'd3));
      drive(0, 0, 0, 1, 2);
      drive(0, 0, 0, 0, 2);
      chk("estop_exit", 32'(obs()), 32'(14'h0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
